// File: rtl/self_trig_arb.sv
// self_trig_arb: collects single-cycle self-trigger pulses from NCH channel
// discriminators. Each pulse is held as a pending request, and pending
// channels are granted round-robin to the shared waveform writer through a
// req/ack/done handshake.
//
// Ports:
//   adcclk      ADC clock. All logic runs on its rising edge.
//   reset       Asynchronous, active-high. Clears all state.
//   trig        Per-channel trigger pulses, one adcclk long.
//   mask        Per-channel disable. A masked channel's trig is ignored.
//   inhibit_in  Global inhibit. While high, all trig is ignored and no new
//               grant is made.
//   req / chan  Request to the writer and the granted channel index.
//               req is held until ack arrives.
//   ack / done  Writer accepted the request / writer finished recording.
//   ch_inhibit  Inhibit back to each channel's trigger unit.
//   lost        Saturating count of pulses dropped because the channel was
//               already pending or being served.
//   timeout     Sticky watchdog flag.
//
// Build option: define SELFTRIG_TIMEOUT_EN to add a 10-bit watchdog. If REQ
// or BUSY lasts 1023 cycles, the watchdog aborts the grant and sets timeout.
// Without the define, timeout is tied to 0 and REQ/BUSY wait indefinitely.

module self_trig_arb_lane (
  input  logic adcclk,
  input  logic reset,
  input  logic trig,
  input  logic mask,
  input  logic inhibit_in,
  input  logic served,
  input  logic grant_clr,
  output logic pending,
  output logic drop,
  output logic ch_inhibit
);
  logic r_pend;
  logic w_accept, w_set;

  assign w_accept = trig & ~mask & ~inhibit_in;
  assign drop     = w_accept & (r_pend | served);
  assign w_set    = w_accept & ~r_pend & ~served;

  // A pending bit is dropped while the channel is masked. This does not
  // affect a grant that has already been issued.
  always_ff @(posedge adcclk or posedge reset)
    if (reset) r_pend <= 1'b0;
    else       r_pend <= (r_pend | w_set) & ~grant_clr & ~mask;

  assign pending    = r_pend;
  assign ch_inhibit = reset | mask | inhibit_in | r_pend | served;
endmodule

module self_trig_arb #(
  parameter int NCH     = 4,
  parameter int CBITS   = 2,
  parameter int HOLDOFF = 16
) (
  input  logic             adcclk,
  input  logic             reset,
  input  logic [NCH-1:0]   trig,
  input  logic [NCH-1:0]   mask,
  input  logic             inhibit_in,
  output logic             req,
  output logic [CBITS-1:0] chan,
  input  logic             ack,
  input  logic             done,
  output logic [NCH-1:0]   ch_inhibit,
  output logic [15:0]      lost,
  output logic             timeout
);
  localparam int LW = CBITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CBITS-1:0] r_chan, r_rr;
  logic [7:0]       r_hold;
  logic [15:0]      r_lost;

  logic [NCH-1:0]   w_pend, w_pend_eff, w_drop, w_served, w_grant_clr;
  logic             w_found, w_grant, w_hold_ld, w_rr_adv, w_abort, w_wd_hit;
  logic [CBITS-1:0] w_sel;
  logic [LW-1:0]    w_ndrop;
  logic [16:0]      w_lost_sum;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign w_served[i] = (r_state != S_IDLE) && (r_chan == CBITS'(i));
    self_trig_arb_lane u_lane (
      .adcclk     (adcclk),
      .reset      (reset),
      .trig       (trig[i]),
      .mask       (mask[i]),
      .inhibit_in (inhibit_in),
      .served     (w_served[i]),
      .grant_clr  (w_grant_clr[i]),
      .pending    (w_pend[i]),
      .drop       (w_drop[i]),
      .ch_inhibit (ch_inhibit[i])
    );
  end

  // Masked channels are excluded so a bit being cleared this cycle is never
  // granted.
  assign w_pend_eff = w_pend & ~mask;

  // Search upward from r_rr for the first pending channel, wrapping at NCH.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && w_pend_eff[(int'(r_rr) + k) % NCH]) begin
        w_found = 1'b1;
        w_sel   = CBITS'((int'(r_rr) + k) % NCH);
      end
    end
  end

  assign w_grant_clr = w_grant ? (NCH'(1) << w_sel) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_hold_ld   = 1'b0;
    w_rr_adv    = 1'b0;
    w_abort     = w_wd_hit && ((r_state == S_REQ  && !ack) ||
                               (r_state == S_BUSY && !done));
    case (r_state)
      S_IDLE: if (w_found && !inhibit_in) begin
                w_grant     = 1'b1;
                w_state_nxt = S_REQ;
              end
      S_REQ:  if (ack) w_state_nxt = S_BUSY;
      S_BUSY: if (done) begin
                w_state_nxt = S_HOLD;
                w_hold_ld   = 1'b1;
                w_rr_adv    = 1'b1;
              end
      S_HOLD: if (r_hold <= 8'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // An aborted grant still moves the pointer past the stuck channel.
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_rr_adv    = 1'b1;
    end
  end

  always_ff @(posedge adcclk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
      r_rr    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant)   r_chan <= w_sel;
      if (w_rr_adv)  r_rr   <= (r_chan == CBITS'(NCH-1)) ? '0 : r_chan + 1'b1;
      if (w_hold_ld) r_hold <= 8'(HOLDOFF);
      else if (r_state == S_HOLD) r_hold <= r_hold - 8'd1;
    end

  // Several channels can drop a pulse in the same cycle, so the drops are
  // summed before the saturating add.
  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NCH; i++) w_ndrop = w_ndrop + LW'(w_drop[i]);
  end

  assign w_lost_sum = {1'b0, r_lost} + 17'(w_ndrop);

  always_ff @(posedge adcclk or posedge reset)
    if (reset) r_lost <= '0;
    else       r_lost <= w_lost_sum[16] ? 16'hFFFF : w_lost_sum[15:0];

`ifdef SELFTRIG_TIMEOUT_EN
  logic [9:0] r_wd;
  logic       r_to;

  // The watchdog counts consecutive cycles in the same REQ or BUSY state.
  // Any state change restarts it.
  always_ff @(posedge adcclk or posedge reset)
    if (reset) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      if ((r_state == S_REQ || r_state == S_BUSY) && w_state_nxt == r_state)
        r_wd <= r_wd + 10'd1;
      else
        r_wd <= '0;
      if (w_abort) r_to <= 1'b1;
    end

  assign w_wd_hit = (r_wd == 10'h3FF);
  assign timeout  = r_to;
`else
  assign w_wd_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign req  = (r_state == S_REQ);
  assign chan = r_chan;
  assign lost = r_lost;
endmodule

// File: tb/tb_self_trig_arb.sv
module tb_self_trig_arb;
  localparam int NCH = 4, CBITS = 2, HOLDOFF = 16;

  logic             adcclk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   trig = '0, mask = '0;
  logic             inhibit_in = 1'b0, ack = 1'b0, done = 1'b0;
  logic             req, timeout;
  logic [CBITS-1:0] chan;
  logic [NCH-1:0]   ch_inhibit;
  logic [15:0]      lost;

  self_trig_arb #(.NCH(NCH), .CBITS(CBITS), .HOLDOFF(HOLDOFF)) dut (
    .adcclk(adcclk), .reset(reset), .trig(trig), .mask(mask),
    .inhibit_in(inhibit_in), .req(req), .chan(chan), .ack(ack), .done(done),
    .ch_inhibit(ch_inhibit), .lost(lost), .timeout(timeout)
  );

  typedef struct { int ch; int cyc; } grant_t;
  typedef struct { int act; int exp; } chk_t;

  grant_t expq[$];
  chk_t   chkq[$];
  string  nameq[$];
  int     checks = 0, failures = 0, cyc = 0;
  bit     fin = 0, mon_done = 0, req_q = 0;

  always #5 adcclk = ~adcclk;

  initial forever begin
    @(posedge adcclk);
    cyc++;
  end

  // Monitor: every req rising edge is scored against the next expected grant
  // (channel and edge number). Point checks queued by the stimulus are scored
  // here as well.
  initial begin
    grant_t g;
    chk_t   c;
    string  nm;
    forever begin
      @(negedge adcclk);
      if (reset) req_q = 0;
      else begin
        if (req && !req_q) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_req chan=%0d cyc=%0d", chan, cyc);
          end else begin
            g = expq.pop_front();
            if (int'(chan) != g.ch || cyc != g.cyc) begin
              failures++;
              $display("FAIL grant actual chan=%0d cyc=%0d required chan=%0d cyc=%0d",
                       chan, cyc, g.ch, g.cyc);
            end
          end
        end
        req_q = req;
      end
      while (chkq.size() > 0) begin
        c  = chkq.pop_front();
        nm = nameq.pop_front();
        checks++;
        if (c.act != c.exp) begin
          failures++;
          $display("FAIL %s actual=%0d required=%0d", nm, c.act, c.exp);
        end
      end
      if (fin && !mon_done) begin
        checks++;
        if (expq.size() != 0) begin
          failures++;
          $display("FAIL grants_outstanding actual=%0d required=0", expq.size());
        end
        mon_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge adcclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nameq.push_back(nm);
    chkq.push_back('{act, exp});
  endtask

  task automatic expect_grant(input int ch, input int at);
    expq.push_back('{ch, at});
  endtask

  task automatic wait_req();
    for (int i = 0; i < 300; i++) begin
      if (req) break;
      tick();
    end
    chk("req_seen", int'(req), 1);
  endtask

  task automatic get_grant();
    wait_req();
    ack = 1'b1;
    tick();
    chk("req_after_ack", int'(req), 0);
    ack = 1'b0;
  endtask

  // done is sampled on the next edge m+1. The next grant then appears after
  // edge m+1+HOLDOFF+1.
  task automatic finish(input bit has_next, input int nxt);
    done = 1'b1;
    if (has_next) expect_grant(nxt, cyc + HOLDOFF + 2);
    tick();
    done = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_inh", int'(ch_inhibit), 15);
    chk("rst_req", int'(req), 0);
    reset = 1'b0;
    tick();
    chk("rst_chan", int'(chan), 0);
    chk("rst_lost", int'(lost), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("idle_inh", int'(ch_inhibit), 0);

    // Single trig[2]
    trig = 4'b0100;
    expect_grant(2, cyc + 2);
    tick();
    chk("t1_pend_inh", int'(ch_inhibit), 4);
    trig = '0;
    get_grant();
    finish(0, 0);
    chk("t1_hold_inh", int'(ch_inhibit), 4);
    repeat (HOLDOFF + 4) tick();
    chk("t1_req_idle", int'(req), 0);
    chk("t1_inh_idle", int'(ch_inhibit), 0);
    chk("t1_lost", int'(lost), 0);

    // All channels at once, with rr_ptr reset to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    trig = 4'hF;
    expect_grant(0, cyc + 2);
    tick();
    chk("t2_pend_inh", int'(ch_inhibit), 15);
    trig = '0;
    get_grant(); finish(1, 1);
    get_grant(); finish(1, 2);
    get_grant(); finish(1, 3);
    get_grant(); finish(0, 0);
    repeat (HOLDOFF + 4) tick();
    chk("t2_lost", int'(lost), 0);

    // Drops on the served channel; a masked pending bit is cleared
    trig = 4'b0010;
    expect_grant(1, cyc + 2);
    tick();
    trig = '0;
    get_grant();
    trig = 4'b0010; tick(); trig = '0; tick();
    trig = 4'b0010; tick(); trig = '0; tick();
    chk("t3_lost", int'(lost), 2);
    chk("t3_busy_inh", int'(ch_inhibit), 2);
    trig = 4'b1000;
    tick();
    chk("t3_pend3_inh", int'(ch_inhibit), 10);
    trig = '0;
    mask = 4'b1000; tick(); mask = '0; tick();
    chk("t3_mask_clr", int'(ch_inhibit), 2);
    finish(0, 0);
    repeat (HOLDOFF + 4) tick();
    chk("t3_inh_idle", int'(ch_inhibit), 0);
    chk("t3_lost_end", int'(lost), 2);

    // Masked trig and globally inhibited trig
    mask = 4'b0100; trig = 4'b0100;
    tick();
    chk("t4_mask_inh", int'(ch_inhibit), 4);
    trig = '0;
    repeat (4) tick();
    mask = '0;
    chk("t4_mask_lost", int'(lost), 2);
    inhibit_in = 1'b1; trig = 4'b0001;
    tick();
    chk("t4_glob_inh", int'(ch_inhibit), 15);
    trig = '0;
    repeat (4) tick();
    inhibit_in = 1'b0;
    tick();
    chk("t4_inh_idle", int'(ch_inhibit), 0);
    chk("t4_lost", int'(lost), 2);
    chk("t4_req", int'(req), 0);

`ifndef SELFTRIG_TIMEOUT_EN
    // Saturation. rr_ptr is 2, so chan 2 is granted and never acked. The first
    // edge only sets pending bits; each later edge drops 4 pulses. 2 + 4*16383
    // gives 0xFFFE.
    trig = 4'hF;
    expect_grant(2, cyc + 2);
    repeat (16384) tick();
    trig = '0;
    tick();
    chk("t5_lost_fffe", int'(lost), 65534);
    chk("t5_inh", int'(ch_inhibit), 15);
    trig = 4'b0111; tick(); trig = '0;
    chk("t5_lost_sat", int'(lost), 65535);
    trig = 4'b0001; tick(); trig = '0;
    chk("t5_lost_hold", int'(lost), 65535);

    // Reset while in REQ
    reset = 1'b1;
    #1;
    chk("rst_req_drop", int'(req), 0);
    chk("rst_mid_inh", int'(ch_inhibit), 15);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_inh", int'(ch_inhibit), 0);
    chk("post_rst_lost", int'(lost), 0);
`else
    // Watchdog
    reset = 1'b1; tick(); reset = 1'b0; tick();
    trig = 4'b0001;
    expect_grant(0, cyc + 2);
    tick();
    trig = '0;
    repeat (1000) tick();
    chk("to_req_held", int'(req), 1);
    chk("to_flag_low", int'(timeout), 0);
    repeat (40) tick();
    chk("to_req_drop", int'(req), 0);
    chk("to_flag", int'(timeout), 1);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    chk("to_flag_rst", int'(timeout), 0);
`endif

    tick();
    fin = 1;
    for (int i = 0; i < 20 && !mon_done; i++) @(negedge adcclk);
    if (!mon_done) begin
      failures++;
      $display("FAIL monitor_drain actual=0 required=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/self_trig_arb.md
# self_trig_arb

Arbitrates single-cycle self-trigger pulses from NCH per-channel trigger units into one request stream for the shared waveform-writing state machine. Latches pending triggers, grants channels round-robin through a req/ack/done handshake, and drives per-channel inhibit back to the trigger units while a channel is pending or being served. Sits between the per-channel self-trigger discriminators and the event writer in the channel FPGA.

## Interface
- NCH, 4, number of channels arbitrated
- CBITS, 2, channel index width; must equal clog2(NCH)
- HOLDOFF, 16, dead-time cycles after `done` before the next grant; 1..255
- adcclk  in  1  ADC clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- trig  in  NCH  per-channel self-trigger pulses, 1 adcclk each
- mask  in  NCH  1 = channel disabled; its trig is ignored, not counted lost
- inhibit_in  in  1  global inhibit; while 1, all trig ignored, no new grant
- req  out  1  request to writer; held until ack
- chan  out  CBITS  granted channel index; valid and stable while req=1 and in BUSY
- ack  in  1  writer accepted request
- done  in  1  writer finished recording granted channel
- ch_inhibit  out  NCH  inhibit to per-channel trigger units
- lost  out  16  count of triggers dropped because the channel was already pending/served; saturates at 0xFFFF
- timeout  out  1  sticky watchdog flag (see Configuration)

## Operation
- pending[NCH-1:0]: bit i set on trig[i] when mask[i]=0, inhibit_in=0, pending[i]=0 and i is not the served channel; otherwise (unmasked, not globally inhibited) lost increments by 1 per dropped pulse-cycle; multiple drops in one cycle add popcount.
- States: IDLE, REQ, BUSY, HOLD.
- IDLE: if pending≠0 and inhibit_in=0, select first set bit searching upward from rr_ptr (wrapping); load chan, clear that pending bit, set req, go REQ.
- REQ: req=1; on ack go BUSY, req=0. Deasserting inhibit_in has no effect once in REQ.
- BUSY: on done go HOLD, load holdoff counter with HOLDOFF; rr_ptr <= chan+1 (wraps at NCH).
- HOLD: count down; at 1 go IDLE.
- ch_inhibit[i] = mask[i] | inhibit_in | pending[i] | (state≠IDLE and chan==i).
- mask[i] rising while pending[i]=1 clears pending[i]; it does not abort a grant already issued.
- ack or done in the wrong state are ignored.

## Timing
- Reset values: req=0, chan=0, ch_inhibit=all 1 during reset, then follows equation with pending=0, state=IDLE; lost=0, timeout=0, rr_ptr=0.
- trig[i] at edge t -> pending[i]=1 and ch_inhibit[i]=1 after edge t; req=1 after edge t+1 (2-cycle latency from idle).
- ack at edge t -> req=0 after t. done at edge t -> HOLD for HOLDOFF cycles, next req earliest after edge t+HOLDOFF+1.
- Grant cycle with simultaneous trig on the granted channel: pending cleared, pulse counted in lost.
- Simultaneous trig on all channels from IDLE: served in order rr_ptr, rr_ptr+1, ... with no loss.
- Reset asserted mid-handshake: req drops immediately (asynchronous), pending discarded; writer must tolerate.

## Configuration
- SELFTRIG_TIMEOUT_EN defined: 10-bit watchdog counts cycles in REQ or BUSY; at 1023 without ack/done, force IDLE, req=0, set timeout=1 (sticky until reset); rr_ptr advances past aborted channel.
- Undefined: no watchdog; timeout tied 0; REQ/BUSY wait indefinitely.

## Test plan
- Single trig[2] pulse, rr_ptr=0 -> req=1 with chan=2 two cycles later; ack next cycle -> req=0; done -> no req for 16 cycles; lost=0.
- trig=4'b1111 in one cycle -> grants chan 0,1,2,3 in order, each after done+HOLDOFF; lost=0.
- trig[1] twice while chan 1 BUSY -> lost=2, pending[1]=0, ch_inhibit[1]=1 until state returns IDLE.
- mask=4'b0100, trig=4'b0100 -> no req, lost=0; inhibit_in=1 with trig=4'b0001 -> no req, lost=0.
- Preset lost=0xFFFE via drops, drop 3 more -> lost=0xFFFF.
- With SELFTRIG_TIMEOUT_EN: trig[0], never ack -> after 1023 cycles req=0, timeout=1; reset -> timeout=0.
